divider_inv_man: RTL and testbench
==================================

# divider_inv_man

Pipelined reconstruction multiplier that inverts the restoring divider. It takes a quotient (`merchant`), divisor and remainder, and produces `dividend = merchant*divisor + remainder`. The shift-add array is MSB-first with one quotient bit per stage, using the same `data_rdy`/`res_rdy` valid chain as the divider. The block sits after the divider in the datapath as a round-trip checker and is also the encode side of the test harness.

## Interface
- `N`, 5: quotient width; also the original dividend width.
- `M`, 3: divisor and remainder width.
- `P`, N+M: result width; derived, do not override.
- `clk`  in  1  clock; all registers are updated on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (low = in reset).
- `data_rdy`  in  1  operand valid strobe, one operation per high cycle.
- `merchant`  in  N  quotient.
- `divisor`  in  M  divisor.
- `remainder`  in  M  remainder.
- `res_rdy`  out  1  result valid, a one-cycle pulse per operation.
- `dividend`  out  P  reconstructed dividend.
- `fits`  out  1  high when `dividend[P-1:N]` is zero, i.e. the result is representable as an N-bit dividend.
- `rem_ok`  out  1  high when `remainder < divisor`, i.e. a legal divider output.

## Operation
- The block is N register stages, indexed 0..N-1, with no backpressure and a throughput of one operation per cycle.
- **Per-stage state:** each stage holds:
  - `rdy_k`
  - accumulator `acc_k` (P bits)
  - carried copies of quotient, divisor, remainder and `rem_ok`.
- **Stage 0**, enabled by `data_rdy`:
  - `acc_0 = merchant[N-1] ? divisor : 0`
  - `rem_ok_0 = (remainder < divisor)`
- **Stage k, 1 ≤ k ≤ N-1**, enabled by `rdy_{k-1}`:
  - `acc_k = (acc_{k-1} << 1) + (q[N-1-k] ? d : 0)`
  - In stage N-1 the carried remainder is also added.
  - Zero-extend all addends to P bits. The maximum value `(2^N-1)(2^M-1) + 2^M-1 = 2^(N+M) - 2^N` fits in P bits, so the block never overflows.
- **Enable rule:** on every edge `rdy_k <= en_k`. When `en_k` is high, the stage data registers load. When `en_k` is low, the data registers hold their previous value.
- **Outputs:**
  - `res_rdy = rdy_{N-1}`
  - `dividend = acc_{N-1}`
  - `rem_ok = rem_ok_{N-1}`
  - `fits` is a combinational function of `dividend`.
  - Outputs hold the last result while `res_rdy` is low.
- **Divisor 0:** `dividend = remainder`, `rem_ok = 0`. This is not an error condition; no special state.
- **Reset:** asserting `reset` low clears every `rdy_k` and data register immediately. Reset values:
  - `res_rdy = 0`
  - `dividend = 0`
  - `rem_ok = 0`
  - `fits = 1` (derived from the zero dividend)
- **Reset mid-flight:** operations in flight are discarded and produce no `res_rdy`. The first `data_rdy` sampled after reset release behaves as from idle.
- **Operand timing:** operands are sampled only on edges where `data_rdy = 1`. They may change freely in any other cycle.

## Timing
- **Latency:** N cycles. Operands sampled with `data_rdy = 1` at edge t produce `res_rdy = 1` with a valid result after edge t+N-1, visible in the cycle following that edge. With the default N, `res_rdy` rises 5 cycles after `data_rdy`.
- **Ordering:** results emerge in issue order. The gap pattern of `data_rdy` is reproduced exactly on `res_rdy`, shifted by N.
- **Back-to-back:** consecutive `data_rdy` cycles give consecutive `res_rdy` cycles, each carrying its own result. Stages hold no shared state.
- **Critical path:** one P-bit add per stage. `fits` adds one P-bit zero-compare after the output register.

## Test plan
- **Nominal:** reset low for 3 cycles, then `merchant=7`, `divisor=3`, `remainder=2`, `data_rdy` for 1 cycle → after 5 cycles `res_rdy` pulses once with `dividend=23`, `fits=1`, `rem_ok=1`.
- **Maximum:** `merchant=31`, `divisor=7`, `remainder=6` → `dividend=223` (0xDF), `fits=0`, `rem_ok=1`.
- **Stream:** three consecutive cycles of operands (5,4,1), (0,7,6), (10,3,3) → `res_rdy` high for 3 consecutive cycles with `dividend` values 21, 6, 33. In between, insert a 2-cycle `data_rdy` gap followed by (1,1,0) → the gap appears on `res_rdy`, then `dividend=1`.
- **Illegal inputs:** `divisor=0`, `remainder=5`, `merchant=9` → `dividend=5`, `rem_ok=0`. Separately, `divisor=2`, `remainder=3` → `rem_ok=0`.
- **Reset mid-flight:** issue 2 operations, then assert `reset` low 2 cycles later → no `res_rdy` for either operation; outputs read 0 immediately. A new operation issued after release yields a correct result after 5 cycles.
- **Round-trip:** drive random dividends/divisors (divisor ≠ 0) through the divider into this block → every result equals the original dividend, with `fits=1` and `rem_ok=1`.

Source files
------------

// File: rtl/divider_inv_man.sv
// Pipelined shift-add reconstruction: dividend = merchant*divisor + remainder.
// One quotient bit per stage, MSB first, with a data_rdy -> res_rdy valid chain.
module divider_inv_man #(
  parameter  int unsigned N = 5,
  parameter  int unsigned M = 3,
  localparam int unsigned P = N + M
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         data_rdy,
  input  logic [N-1:0] merchant,
  input  logic [M-1:0] divisor,
  input  logic [M-1:0] remainder,
  output logic         res_rdy,
  output logic [P-1:0] dividend,
  output logic         fits,
  output logic         rem_ok
);

  logic [N-1:0]         rdy_q, rdy_d;
  logic [N-1:0][P-1:0]  acc_q, acc_d;
  logic [N-1:0]         ok_q, ok_d;
  // Operand copies are only needed by stages that feed another stage.
  logic [N-2:0][N-1:0]  q_q, q_d;
  logic [N-2:0][M-1:0]  d_q, d_d;
  logic [N-2:0][M-1:0]  r_q, r_d;

  always_comb begin
    rdy_d = {rdy_q[N-2:0], data_rdy};
    acc_d = acc_q;
    ok_d  = ok_q;
    q_d   = q_q;
    d_d   = d_q;
    r_d   = r_q;

    if (data_rdy) begin
      acc_d[0] = merchant[N-1] ? P'(divisor) : '0;
      ok_d[0]  = (remainder < divisor);
      q_d[0]   = merchant << 1;
      d_d[0]   = divisor;
      r_d[0]   = remainder;
    end

    // The carried quotient is shifted each stage so the next bit is always the MSB.
    for (int unsigned k = 1; k < N - 1; k++) begin
      if (rdy_q[k-1]) begin
        acc_d[k] = (acc_q[k-1] << 1) + (q_q[k-1][N-1] ? P'(d_q[k-1]) : '0);
        ok_d[k]  = ok_q[k-1];
        q_d[k]   = q_q[k-1] << 1;
        d_d[k]   = d_q[k-1];
        r_d[k]   = r_q[k-1];
      end
    end

    // By the last stage only merchant[0] survives the shifts, so OR-reduce it.
    if (rdy_q[N-2]) begin
      acc_d[N-1] = (acc_q[N-2] << 1) + ((|q_q[N-2]) ? P'(d_q[N-2]) : '0)
                 + P'(r_q[N-2]);
      ok_d[N-1]  = ok_q[N-2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_q <= '0;
      acc_q <= '0;
      ok_q  <= '0;
      q_q   <= '0;
      d_q   <= '0;
      r_q   <= '0;
    end else begin
      rdy_q <= rdy_d;
      acc_q <= acc_d;
      ok_q  <= ok_d;
      q_q   <= q_d;
      d_q   <= d_d;
      r_q   <= r_d;
    end
  end

  assign res_rdy  = rdy_q[N-1];
  assign dividend = acc_q[N-1];
  assign rem_ok   = ok_q[N-1];
  assign fits     = ~|dividend[P-1:N];

endmodule

// File: tb/tb_divider_inv_man.sv
// Directed and round-trip bench for divider_inv_man with a result scoreboard.
module tb_divider_inv_man;
  localparam int N = 5;
  localparam int M = 3;
  localparam int P = N + M;

  typedef struct {
    int div;
    bit fits;
    bit ok;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         data_rdy = 1'b0;
  logic [N-1:0] merchant = '0;
  logic [M-1:0] divisor = '0;
  logic [M-1:0] remainder = '0;
  logic         res_rdy;
  logic [P-1:0] dividend;
  logic         fits;
  logic         rem_ok;

  int n_checks = 0;
  int n_errors = 0;
  int n_issued = 0;
  int n_results = 0;
  int cyc = 0;
  int last_div = 0;
  exp_t exp_q[$];
  int   stamp_q[$];

  divider_inv_man #(.N(N), .M(M)) dut (
    .clk(clk), .reset(reset), .data_rdy(data_rdy), .merchant(merchant),
    .divisor(divisor), .remainder(remainder), .res_rdy(res_rdy),
    .dividend(dividend), .fits(fits), .rem_ok(rem_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (data_rdy && reset) stamp_q.push_back(cyc);
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (reset) begin
      if (res_rdy) begin
        if (exp_q.size() == 0 || stamp_q.size() == 0) begin
          check("spurious_res_rdy", 32'(res_rdy), 32'd0);
        end else begin
          exp_t e;
          int s;
          e = exp_q.pop_front();
          s = stamp_q.pop_front();
          check("dividend", 32'(dividend), 32'(e.div));
          check("fits", 32'(fits), 32'(e.fits));
          check("rem_ok", 32'(rem_ok), 32'(e.ok));
          check("latency", 32'(cyc - s), 32'(N));
          last_div = int'(dividend);
          n_results++;
        end
      end else begin
        check("hold", 32'(dividend), 32'(last_div));
      end
    end
  end

  task automatic issue(input int m, input int d, input int r,
                       input int ed, input bit ef, input bit eo);
    merchant  = N'(m);
    divisor   = M'(d);
    remainder = M'(r);
    data_rdy  = 1'b1;
    exp_q.push_back('{ed, ef, eo});
    n_issued++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    data_rdy = 1'b0;
    repeat (n) begin
      merchant  = N'($urandom);
      divisor   = M'($urandom);
      remainder = M'($urandom);
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_res_rdy", 32'(res_rdy), 32'd0);
    check("rst_dividend", 32'(dividend), 32'd0);
    check("rst_rem_ok", 32'(rem_ok), 32'd0);
    check("rst_fits", 32'(fits), 32'd1);
    reset = 1'b1;
    last_div = 0;

    issue(7, 3, 2, 23, 1'b1, 1'b1);
    idle(N + 2);
    issue(31, 7, 6, 223, 1'b0, 1'b1);
    idle(N + 2);

    issue(5, 4, 1, 21, 1'b1, 1'b1);
    issue(0, 7, 6, 6, 1'b1, 1'b1);
    issue(10, 3, 3, 33, 1'b0, 1'b0);
    idle(2);
    issue(1, 1, 0, 1, 1'b1, 1'b1);
    idle(N + 2);

    issue(9, 0, 5, 5, 1'b1, 1'b0);
    issue(4, 2, 3, 11, 1'b1, 1'b0);
    idle(N + 2);

    issue(6, 5, 4, 34, 0, 1);
    issue(3, 6, 1, 19, 1, 1);
    idle(2);
    reset = 1'b0;
    #1;
    check("midrst_res_rdy", 32'(res_rdy), 32'd0);
    check("midrst_dividend", 32'(dividend), 32'd0);
    check("midrst_rem_ok", 32'(rem_ok), 32'd0);
    check("midrst_fits", 32'(fits), 32'd1);
    n_issued -= exp_q.size();
    exp_q.delete();
    stamp_q.delete();
    last_div = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    issue(2, 7, 5, 19, 1'b1, 1'b1);
    idle(N + 2);

    for (int i = 0; i < 24; i++) begin
      int x;
      int d;
      x = int'($urandom_range(0, 31));
      d = int'($urandom_range(1, 7));
      issue(x / d, d, x % d, x, 1'b1, 1'b1);
      if ((i % 5) == 4) idle(1);
    end
    data_rdy = 1'b0;

    for (int w = 0; w < 4 * N && exp_q.size() != 0; w++) @(negedge clk);
    idle(2);
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    check("result_count", 32'(n_results), 32'(n_issued));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
